multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Parametrised multi-cycle main control FSM for the MIPS-subset CPU; successor to the single-cycle decoder.
//  Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps.
//  Stretches memory steps with a ready handshake and adds j plus illegal-opcode trapping.
//  Sits between the instruction register opcode field and the datapath muxes, register file and memory port.
// PARAMETERS
//  ALUCTR_W    2      width of ALUctr
//  ALU_ADD     2'b00  ALUctr code for address/PC add (lw, sw, fetch PC+4, decode branch target)
//  ALU_SUB     2'b01  ALUctr code for beq compare
//  ALU_RTYPE   2'b10  ALUctr code: ALU control decodes funct
//  ALU_LUI     2'b11  ALUctr code for lui
//  MEM_HS      1      1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         synchronous active-low reset
//  op           in   6         opcode from IR[31:26]
//  zero         in   1         ALU zero flag
//  mem_ready    in   1         memory completes current access this cycle
//  PCWrite      out  1         unconditional PC load
//  PCWriteCond  out  1         PC load if zero
//  IorD         out  1         memory address: 0=PC, 1=ALUOut
//  MemRead      out  1         memory read request
//  MemWrite     out  1         memory write request
//  IRWrite      out  1         load IR
//  MemtoReg     out  1         register write data: 1=MDR, 0=ALUOut
//  RegDst       out  1         1=rd, 0=rt
//  RegWrite     out  1         register file write
//  ALUSrcA      out  1         0=PC, 1=rs
//  ALUSrcB      out  2         00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
//  PCSource     out  2         00=ALU result, 01=ALUOut, 10=jump target
//  ALUctr       out  ALUCTR_W  ALU operation class
//  instr_done   out  1         1-cycle pulse in the last state of each instruction
//  illegal_op   out  1         1-cycle pulse in DECODE when opcode is unsupported
//  state        out  4         current state, for debug
// BEHAVIOUR
//  - Supported opcodes: R 000000; lw 100011; sw 101011; beq 000100; lui 001111; j 000010.
//  - Reset: when rst_n=0 at a clk edge, state<=FETCH. While rst_n=0, every output is forced to 0, including state.
//  - Outputs are combinational from state, plus mem_ready where noted. Signals not listed for a state are 0.
//  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=ALU_ADD, PCSource=00.
//    If mem_ready: IRWrite=1, PCWrite=1, next=DECODE; else stay in FETCH.
//  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUctr=ALU_ADD (precompute branch target).
//    Next by op: lw/sw->MEMADR; R->EXEC_R; beq->BRANCH; lui->EXEC_LUI; j->JUMP.
//    Any other op: illegal_op=1, instr_done=1, next=FETCH; PC stays at the already-incremented value.
//  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUctr=ALU_ADD. Next: lw->MEMRD, sw->MEMWR.
//  - MEMRD(3): MemRead=1, IorD=1. If mem_ready, next=MEMWB; else stay.
//  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, next=FETCH.
//  - MEMWR(5): MemWrite=1, IorD=1. If mem_ready: instr_done=1, next=FETCH; else stay.
//  - EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUctr=ALU_RTYPE, next=RWB.
//  - RWB(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, next=FETCH.
//  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUctr=ALU_SUB, PCWriteCond=1, PCSource=01, instr_done=1, next=FETCH.
//  - EXEC_LUI(9): ALUSrcA=1, ALUSrcB=10, ALUctr=ALU_LUI, next=LUIWB.
//  - LUIWB(10): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, next=FETCH.
//  - JUMP(11): PCWrite=1, PCSource=10, instr_done=1, next=FETCH.
//  - Unused state encodings (12-15): next=FETCH, all outputs 0.
//  - Cycle counts with zero wait: R=4, lw=5, sw=4, beq=3, lui=4, j=3, illegal=2.
//    Each memory wait cycle adds 1.
//  - op is sampled only in DECODE and MEMADR. Changes in op during other states have no effect.
//  - MemRead/MemWrite stay asserted and stable through wait cycles. They are never both 1 in any cycle.
//  - rst_n low mid-instruction (including during a memory wait) aborts the instruction: FETCH on the next edge, no pending write.
// TESTING
//  1. rst_n=0 for 2 cycles, then 1, mem_ready=1 -> all outputs 0 during reset. First cycle after release: state=0, MemRead=1, IRWrite=1, PCWrite=1.
//  2. op=100011, mem_ready=1 -> states 0,1,2,3,4. RegWrite=1 and MemtoReg=1 only in state 4. instr_done at cycle 5.
//  3. op=101011, mem_ready low for 3 cycles in MEMWR -> MEMWR held 4 cycles, MemWrite=1 throughout, RegWrite never 1, instr_done on the ready cycle.
//  4. op=000100, zero=1 then zero=0 -> BRANCH: PCWriteCond=1, PCSource=01, ALUctr=01. Total 3 cycles each.
//  5. op=111111 -> illegal_op pulse in DECODE, no RegWrite/MemWrite, back in FETCH after 2 cycles.
//  6. rst_n=0 asserted while stalled in MEMRD -> state=FETCH next edge, RegWrite never asserted for that lw.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the MIPS-subset CPU.
// Breaks each instruction into FETCH/DECODE/EXEC/MEM/WB steps, stretches the
// memory steps with a ready handshake, and traps unsupported opcodes in DECODE.
// All control outputs are decoded combinationally from the current state
// (plus mem_ready where a step completes on it) and are held at 0 in reset.
module multicycle_control #(
  parameter int unsigned          ALUCTR_W  = 2,
  parameter logic [ALUCTR_W-1:0]  ALU_ADD   = 2'b00,
  parameter logic [ALUCTR_W-1:0]  ALU_SUB   = 2'b01,
  parameter logic [ALUCTR_W-1:0]  ALU_RTYPE = 2'b10,
  parameter logic [ALUCTR_W-1:0]  ALU_LUI   = 2'b11,
  parameter bit                   MEM_HS    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC_R   = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8,
    EXEC_LUI = 4'd9,
    LUIWB    = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   mem_rdy_s;

  // Without the handshake every memory access completes in one cycle.
  assign mem_rdy_s = (MEM_HS) ? mem_ready : 1'b1;

  // Debug view of the state; forced to 0 while reset is held.
  assign state = rst_n ? state_r : 4'd0;

  // State register with synchronous active-low reset back to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control-output decode; everything defaults to 0 so a
  // state only lists the signals it actually drives.
  always_comb begin
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSource     = 2'b00;
    ALUctr       = '0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    next_state_s = FETCH;
    if (!rst_n) begin
      // Reset aborts whatever was in flight; no request may leak out.
      next_state_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          MemRead  = 1'b1;
          ALUSrcB  = 2'b01;
          ALUctr   = ALU_ADD;
          if (mem_rdy_s) begin
            IRWrite      = 1'b1;
            PCWrite      = 1'b1;
            next_state_s = DECODE;
          end else begin
            next_state_s = FETCH;
          end
        end
        DECODE: begin
          // Branch target is computed speculatively while the opcode decodes.
          ALUSrcB = 2'b11;
          ALUctr  = ALU_ADD;
          case (op)
            OP_LW, OP_SW: next_state_s = MEMADR;
            OP_R:         next_state_s = EXEC_R;
            OP_BEQ:       next_state_s = BRANCH;
            OP_LUI:       next_state_s = EXEC_LUI;
            OP_J:         next_state_s = JUMP;
            default: begin
              // PC has already advanced past the bad word; just restart.
              illegal_op   = 1'b1;
              instr_done   = 1'b1;
              next_state_s = FETCH;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUctr  = ALU_ADD;
          if (op == OP_SW) begin
            next_state_s = MEMWR;
          end else begin
            next_state_s = MEMRD;
          end
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_rdy_s) begin
            next_state_s = MEMWB;
          end else begin
            next_state_s = MEMRD;
          end
        end
        MEMWB: begin
          RegWrite     = 1'b1;
          MemtoReg     = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_rdy_s) begin
            instr_done   = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = MEMWR;
          end
        end
        EXEC_R: begin
          ALUSrcA      = 1'b1;
          ALUctr       = ALU_RTYPE;
          next_state_s = RWB;
        end
        RWB: begin
          RegWrite     = 1'b1;
          RegDst       = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        BRANCH: begin
          // The datapath gates PCWriteCond with zero; the FSM never waits on it.
          ALUSrcA      = 1'b1;
          ALUctr       = ALU_SUB;
          PCWriteCond  = 1'b1;
          PCSource     = 2'b01;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        EXEC_LUI: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          ALUctr       = ALU_LUI;
          next_state_s = LUIWB;
        end
        LUIWB: begin
          RegWrite     = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        JUMP: begin
          PCWrite      = 1'b1;
          PCSource     = 2'b10;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        default: begin
          // Unused encodings recover to FETCH with every output idle.
          next_state_s = FETCH;
        end
      endcase
    end
  end

  // zero is consumed by the datapath's PC-enable logic, not by this FSM.
  logic unused_zero_s;
  assign unused_zero_s = zero;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class through
// its state sequence and compares all control outputs each cycle.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALUctr;
  logic       instr_done, illegal_op;
  logic [3:0] state;
  logic [21:0] obs;

  int passed = 0;
  int total  = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUctr(ALUctr), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                ALUctr, instr_done, illegal_op, state};

  function automatic logic [21:0] v(
    input logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
    input logic [1:0] asb, pcs, actr,
    input logic done, ill,
    input logic [3:0] st);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
            asb, pcs, actr, done, ill, st};
  endfunction

  // Expected output vectors, hand-derived from the state table.
  logic [21:0] e_fetch, e_fetch_wait, e_decode, e_decode_ill, e_memadr, e_memrd;
  logic [21:0] e_memwb, e_memwr_wait, e_memwr, e_exec_r, e_rwb, e_branch;
  logic [21:0] e_exec_lui, e_luiwb, e_jump;

  // Compare at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [21:0] exp);
    @(negedge clk);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               pcw pcwc iord mr mw irw m2r rdst rw asa asb    pcs    actr   dn il st
    e_fetch      = v(1,  0,   0,   1, 0, 1,  0,  0,   0, 0,  2'b01, 2'b00, 2'b00, 0, 0, 4'd0);
    e_fetch_wait = v(0,  0,   0,   1, 0, 0,  0,  0,   0, 0,  2'b01, 2'b00, 2'b00, 0, 0, 4'd0);
    e_decode     = v(0,  0,   0,   0, 0, 0,  0,  0,   0, 0,  2'b11, 2'b00, 2'b00, 0, 0, 4'd1);
    e_decode_ill = v(0,  0,   0,   0, 0, 0,  0,  0,   0, 0,  2'b11, 2'b00, 2'b00, 1, 1, 4'd1);
    e_memadr     = v(0,  0,   0,   0, 0, 0,  0,  0,   0, 1,  2'b10, 2'b00, 2'b00, 0, 0, 4'd2);
    e_memrd      = v(0,  0,   1,   1, 0, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 4'd3);
    e_memwb      = v(0,  0,   0,   0, 0, 0,  1,  0,   1, 0,  2'b00, 2'b00, 2'b00, 1, 0, 4'd4);
    e_memwr_wait = v(0,  0,   1,   0, 1, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 0, 0, 4'd5);
    e_memwr      = v(0,  0,   1,   0, 1, 0,  0,  0,   0, 0,  2'b00, 2'b00, 2'b00, 1, 0, 4'd5);
    e_exec_r     = v(0,  0,   0,   0, 0, 0,  0,  0,   0, 1,  2'b00, 2'b00, 2'b10, 0, 0, 4'd6);
    e_rwb        = v(0,  0,   0,   0, 0, 0,  0,  1,   1, 0,  2'b00, 2'b00, 2'b00, 1, 0, 4'd7);
    e_branch     = v(0,  1,   0,   0, 0, 0,  0,  0,   0, 1,  2'b00, 2'b01, 2'b01, 1, 0, 4'd8);
    e_exec_lui   = v(0,  0,   0,   0, 0, 0,  0,  0,   0, 1,  2'b10, 2'b00, 2'b11, 0, 0, 4'd9);
    e_luiwb      = v(0,  0,   0,   0, 0, 0,  0,  0,   1, 0,  2'b00, 2'b00, 2'b00, 1, 0, 4'd10);
    e_jump       = v(1,  0,   0,   0, 0, 0,  0,  0,   0, 0,  2'b00, 2'b10, 2'b00, 1, 0, 4'd11);

    // Reset held two cycles: everything forced to 0.
    rst_n = 1'b0; op = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
    #1;
    cyc("reset_c0", 22'd0);
    cyc("reset_c1", 22'd0);

    // lw with no waits: 0,1,2,3,4.
    rst_n = 1'b1;
    cyc("lw_fetch", e_fetch);
    cyc("lw_decode", e_decode);
    cyc("lw_memadr", e_memadr);
    cyc("lw_memrd", e_memrd);
    cyc("lw_memwb", e_memwb);

    // sw with 3 wait cycles; op scrambled during the wait must not matter.
    op = 6'b101011;
    cyc("sw_fetch", e_fetch);
    cyc("sw_decode", e_decode);
    cyc("sw_memadr", e_memadr);
    mem_ready = 1'b0;
    cyc("sw_wait0", e_memwr_wait);
    op = 6'b111111;
    cyc("sw_wait1", e_memwr_wait);
    cyc("sw_wait2", e_memwr_wait);
    mem_ready = 1'b1;
    cyc("sw_memwr_done", e_memwr);

    // R-type.
    op = 6'b000000;
    cyc("r_fetch", e_fetch);
    cyc("r_decode", e_decode);
    cyc("r_exec", e_exec_r);
    cyc("r_wb", e_rwb);

    // beq taken then not taken: both 3 cycles.
    op = 6'b000100; zero = 1'b1;
    cyc("beq1_fetch", e_fetch);
    cyc("beq1_decode", e_decode);
    cyc("beq1_branch", e_branch);
    zero = 1'b0;
    cyc("beq0_fetch", e_fetch);
    cyc("beq0_decode", e_decode);
    cyc("beq0_branch", e_branch);

    // lui.
    op = 6'b001111;
    cyc("lui_fetch", e_fetch);
    cyc("lui_decode", e_decode);
    cyc("lui_exec", e_exec_lui);
    cyc("lui_wb", e_luiwb);

    // j, with one fetch wait cycle first.
    op = 6'b000010; mem_ready = 1'b0;
    cyc("j_fetch_wait", e_fetch_wait);
    mem_ready = 1'b1;
    cyc("j_fetch", e_fetch);
    cyc("j_decode", e_decode);
    cyc("j_jump", e_jump);

    // Illegal opcode: pulse in DECODE, then straight back to FETCH.
    op = 6'b111111;
    cyc("ill_fetch", e_fetch);
    cyc("ill_decode", e_decode_ill);

    // lw aborted by reset while stalled in MEMRD.
    op = 6'b100011;
    cyc("abort_fetch", e_fetch);
    cyc("abort_decode", e_decode);
    cyc("abort_memadr", e_memadr);
    mem_ready = 1'b0;
    cyc("abort_memrd0", e_memrd);
    cyc("abort_memrd1", e_memrd);
    rst_n = 1'b0;
    cyc("abort_in_reset", 22'd0);
    rst_n = 1'b1; mem_ready = 1'b1;
    cyc("abort_refetch", e_fetch);
    cyc("abort_redecode", e_decode);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
